// File: rtl/fp_comp_issue.sv
// fp_comp_issue: issue sequencer for the floating-point comparator.
// It accepts one compare command at a time on a valid/ready request port,
// drives the operands and a one-cycle act pulse to an external comparator,
// waits for the comparator's registered result, and returns the result on
// a valid/ready response port. Only one operation is in flight at a time.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid/req_ready       command handshake; req_op/req_a/req_b payload
//                             (op 0 EQ, 1 LT, 2 LE, 3 MIN, 4 MAX, 5-7 illegal)
//   cmp_in1/cmp_in2/cmp_act   operands and start pulse to the comparator
//   cmp_eq/great/less/done/inv   comparator results
//   rsp_valid/rsp_ready       response handshake
//   rsp_data                  MIN/MAX selected operand, zero for EQ/LT/LE
//   rsp_flag                  boolean result for EQ/LT/LE, zero for MIN/MAX
//   rsp_inv / rsp_timeout     invalid result / comparator never finished
//   stat_ops / stat_inv       saturating statistics counters
//
// Build option: define FP_CMP_ISSUE_STATS_EN to enable the statistics
// counters; otherwise stat_ops/stat_inv are tied to zero.
module fp_comp_issue #(
    parameter int W       = 32,
    parameter int LAT     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic [W-1:0] cmp_in1,
    output logic [W-1:0] cmp_in2,
    output logic         cmp_act,
    input  logic         cmp_eq,
    input  logic         cmp_great,
    input  logic         cmp_less,
    input  logic         cmp_done,
    input  logic         cmp_inv,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_flag,
    output logic         rsp_inv,
    output logic         rsp_timeout,
    output logic [15:0]  stat_ops,
    output logic [15:0]  stat_inv
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAT_C     = CW'(LAT);
    // Last WAIT count; leaving here makes the response appear TIMEOUT cycles after act.
    localparam logic [CW-1:0] TO_LAST_C = CW'(TIMEOUT - 1);
    localparam logic [W-1:0]  QNAN_C    = W'(32'h7FC0_0000);

    localparam logic [2:0] OP_EQ  = 3'd0;
    localparam logic [2:0] OP_LT  = 3'd1;
    localparam logic [2:0] OP_LE  = 3'd2;
    localparam logic [2:0] OP_MIN = 3'd3;
    localparam logic [2:0] OP_MAX = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           req_ready_q, req_ready_d;
    logic           cmp_act_q, cmp_act_d;
    logic [W-1:0]   cmp_in1_q, cmp_in1_d;
    logic [W-1:0]   cmp_in2_q, cmp_in2_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic           rsp_flag_q, rsp_flag_d;
    logic           rsp_inv_q, rsp_inv_d;
    logic           rsp_timeout_q, rsp_timeout_d;

    logic [W-1:0]   res_data_s;
    logic           res_flag_s;
    logic           res_inv_s;

    // Translate the comparator flags into a response for the latched op.
    always_comb begin
        res_data_s = {W{1'b0}};
        res_flag_s = 1'b0;
        res_inv_s  = cmp_inv;
        if (cmp_inv) begin
            if ((op_q == OP_MIN) || (op_q == OP_MAX)) begin
                res_data_s = QNAN_C;
            end else begin
                res_data_s = {W{1'b0}};
            end
        end else begin
            case (op_q)
                OP_EQ:   res_flag_s = cmp_eq;
                OP_LT:   res_flag_s = cmp_less;
                OP_LE:   res_flag_s = cmp_less | cmp_eq;
                // Ties return operand A for both MIN and MAX.
                OP_MIN:  res_data_s = cmp_great ? cmp_in2_q : cmp_in1_q;
                OP_MAX:  res_data_s = cmp_less  ? cmp_in2_q : cmp_in1_q;
                default: res_inv_s  = 1'b1;
            endcase
        end
    end

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        req_ready_d   = 1'b0;
        cmp_act_d     = 1'b0;
        cmp_in1_d     = cmp_in1_q;
        cmp_in2_d     = cmp_in2_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_flag_d    = rsp_flag_q;
        rsp_inv_d     = rsp_inv_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d      = req_op;
                    cmp_in1_d = req_a;
                    cmp_in2_d = req_b;
                    if (req_op <= OP_MAX) begin
                        state_d   = S_ISSUE;
                        cmp_act_d = 1'b1;
                        cnt_d     = {CW{1'b0}};
                    end else begin
                        // Illegal op: answer directly without touching the comparator.
                        state_d       = S_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_data_d    = {W{1'b0}};
                        rsp_flag_d    = 1'b0;
                        rsp_inv_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = cnt_q + CW'(1);
            end
            S_WAIT: begin
                // Below LAT the comparator still shows the previous operation.
                if ((cnt_q >= LAT_C) && cmp_done) begin
                    state_d       = S_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = res_data_s;
                    rsp_flag_d    = res_flag_s;
                    rsp_inv_d     = res_inv_s;
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == TO_LAST_C) begin
                    state_d       = S_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = {W{1'b0}};
                    rsp_flag_d    = 1'b0;
                    rsp_inv_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            op_q          <= 3'd0;
            cnt_q         <= {CW{1'b0}};
            req_ready_q   <= 1'b0;
            cmp_act_q     <= 1'b0;
            cmp_in1_q     <= {W{1'b0}};
            cmp_in2_q     <= {W{1'b0}};
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= {W{1'b0}};
            rsp_flag_q    <= 1'b0;
            rsp_inv_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            cmp_act_q     <= cmp_act_d;
            cmp_in1_q     <= cmp_in1_d;
            cmp_in2_q     <= cmp_in2_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_flag_q    <= rsp_flag_d;
            rsp_inv_q     <= rsp_inv_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign cmp_act     = cmp_act_q;
    assign cmp_in1     = cmp_in1_q;
    assign cmp_in2     = cmp_in2_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_flag    = rsp_flag_q;
    assign rsp_inv     = rsp_inv_q;
    assign rsp_timeout = rsp_timeout_q;

`ifdef FP_CMP_ISSUE_STATS_EN
    logic [15:0] stat_ops_q;
    logic [15:0] stat_inv_q;

    // Saturating counts of issued operations and invalid responses delivered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_ops_q <= 16'h0000;
            stat_inv_q <= 16'h0000;
        end else begin
            if ((state_q == S_ISSUE) && (stat_ops_q != 16'hFFFF)) begin
                stat_ops_q <= stat_ops_q + 16'd1;
            end
            if (rsp_valid_q && rsp_ready && rsp_inv_q && (stat_inv_q != 16'hFFFF)) begin
                stat_inv_q <= stat_inv_q + 16'd1;
            end
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_inv = stat_inv_q;
`else
    assign stat_ops = 16'h0000;
    assign stat_inv = 16'h0000;
`endif

endmodule

// File: tb/tb_fp_comp_issue.sv
module tb_fp_comp_issue;

    localparam int W       = 32;
    localparam int LAT     = 2;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_op = 3'd0;
    logic [W-1:0]  req_a = 32'd0;
    logic [W-1:0]  req_b = 32'd0;
    logic [W-1:0]  cmp_in1, cmp_in2;
    logic          cmp_act;
    logic          cmp_eq, cmp_great, cmp_less, cmp_done, cmp_inv;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic          rsp_flag, rsp_inv, rsp_timeout;
    logic [15:0]   stat_ops, stat_inv;

    int checks   = 0;
    int failures = 0;
    int ops_exp  = 0;
    int inv_exp  = 0;

    always #5 clk = ~clk;

    fp_comp_issue #(.W(W), .LAT(LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .cmp_in1(cmp_in1), .cmp_in2(cmp_in2), .cmp_act(cmp_act),
        .cmp_eq(cmp_eq), .cmp_great(cmp_great), .cmp_less(cmp_less),
        .cmp_done(cmp_done), .cmp_inv(cmp_inv),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flag(rsp_flag), .rsp_inv(rsp_inv), .rsp_timeout(rsp_timeout),
        .stat_ops(stat_ops), .stat_inv(stat_inv)
    );

    // Comparator model: results appear m_d cycles after the act cycle. The
    // previous results linger for one cycle after act, then done drops.
    int   m_d = 2;
    logic m_eq = 1'b0, m_gt = 1'b0, m_lt = 1'b0, m_inv = 1'b0;
    int   age, op_d, na, sel_d;
    logic op_eq, op_gt, op_lt, op_inv;
    logic s_eq, s_gt, s_lt, s_inv;

    always_comb begin
        na    = cmp_act ? 1 : ((age < 1000) ? age + 1 : age);
        sel_d = cmp_act ? m_d : op_d;
        s_eq  = cmp_act ? m_eq  : op_eq;
        s_gt  = cmp_act ? m_gt  : op_gt;
        s_lt  = cmp_act ? m_lt  : op_lt;
        s_inv = cmp_act ? m_inv : op_inv;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            age <= 1000; op_d <= 2000;
            op_eq <= 1'b0; op_gt <= 1'b0; op_lt <= 1'b0; op_inv <= 1'b0;
            cmp_done <= 1'b0; cmp_eq <= 1'b0; cmp_great <= 1'b0;
            cmp_less <= 1'b0; cmp_inv <= 1'b0;
        end else begin
            age <= na;
            if (cmp_act) begin
                op_d <= m_d; op_eq <= m_eq; op_gt <= m_gt; op_lt <= m_lt; op_inv <= m_inv;
            end
            if (na >= sel_d) begin
                cmp_done <= 1'b1; cmp_eq <= s_eq; cmp_great <= s_gt;
                cmp_less <= s_lt; cmp_inv <= s_inv;
            end else if (na >= 2) begin
                cmp_done <= 1'b0; cmp_eq <= 1'b0; cmp_great <= 1'b0;
                cmp_less <= 1'b0; cmp_inv <= 1'b0;
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete command: issue, wait for the response, optionally stall it, retire.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int d, input logic eq, input logic gt, input logic lt,
                         input logic inv, input int hold);
        int n, acts, s, exp_lat;
        logic legal, e_to, e_inv, e_flag;
        logic [31:0] e_data;
        legal  = (op <= 3'd4);
        s      = (d < LAT) ? LAT : d;
        e_to   = legal && (s > TIMEOUT - 1);
        e_inv  = 1'b0; e_flag = 1'b0; e_data = 32'd0;
        if (!legal) begin
            exp_lat = 0; e_inv = 1'b1;
        end else if (e_to) begin
            exp_lat = TIMEOUT; e_inv = 1'b1;
        end else begin
            exp_lat = s + 1;
            if (inv) begin
                e_inv = 1'b1;
                if (op == 3'd3 || op == 3'd4) e_data = 32'h7FC00000;
            end else begin
                case (op)
                    3'd0: e_flag = eq;
                    3'd1: e_flag = lt;
                    3'd2: e_flag = lt | eq;
                    3'd3: e_data = gt ? b : a;
                    default: e_data = lt ? b : a;
                endcase
            end
        end
        m_d = d; m_eq = eq; m_gt = gt; m_lt = lt; m_inv = inv;

        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check_value("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'($urandom); req_a = $urandom; req_b = $urandom;
        if (legal) ops_exp++;

        n = 0; acts = 0;
        while (!rsp_valid && n < 40) begin
            if (cmp_act) begin
                acts++;
                check_value("act_in1", cmp_in1, a);
                check_value("act_in2", cmp_in2, b);
            end
            @(posedge clk); #1; n++;
        end
        check_value("rsp_latency", 32'(n), 32'(exp_lat));
        check_value("act_count", 32'(acts), legal ? 32'd1 : 32'd0);
        check_value("rsp_data", rsp_data, e_data);
        check_value("rsp_flag", 32'(rsp_flag), 32'(e_flag));
        check_value("rsp_inv", 32'(rsp_inv), 32'(e_inv));
        check_value("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
        check_value("req_ready_busy", 32'(req_ready), 32'd0);
        if (legal) check_value("in1_held", cmp_in1, a);
        if (e_inv) inv_exp++;

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_value("stall_valid", 32'(rsp_valid), 32'd1);
            check_value("stall_data", rsp_data, e_data);
            check_value("stall_inv", 32'(rsp_inv), 32'(e_inv));
            check_value("stall_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_value("rsp_retired", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'($urandom);
    endtask

    // Reset k cycles after accepting a never-finishing op; no response may follow.
    task automatic reset_mid(input int k);
        int n;
        m_d = 1000; m_eq = 1'b0; m_gt = 1'b0; m_lt = 1'b0; m_inv = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        req_valid = 1'b1; req_op = 3'd1; req_a = 32'h3F800000; req_b = 32'h40000000;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
        end
        if (k == 0) check_value("act_before_rst", 32'(cmp_act), 32'd1);
        rst = 1'b0;
        #1;
        check_value("rst_act", 32'(cmp_act), 32'd0);
        check_value("rst_ready", 32'(req_ready), 32'd0);
        check_value("rst_in1", cmp_in1, 32'd0);
        check_value("rst_outs", {rsp_valid, rsp_flag, rsp_inv, rsp_timeout}, 32'd0);
        check_value("rst_data", rsp_data, 32'd0);
        check_value("rst_stats", {stat_ops, stat_inv}, 32'd0);
        ops_exp = 0; inv_exp = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rsp_valid || cmp_act) break;
        end
        check_value("no_rsp_after_rst", {rsp_valid, cmp_act}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_ready", 32'(req_ready), 32'd0);
        check_value("reset_outs", {cmp_act, rsp_valid, rsp_flag, rsp_inv, rsp_timeout}, 32'd0);
        check_value("reset_in2", cmp_in2, 32'd0);
        rst = 1'b1;

        do_op(3'd1, 32'h3F800000, 32'h40000000, 2, 1'b0, 1'b0, 1'b1, 1'b0, 0); // LT true
        do_op(3'd4, 32'hC0000000, 32'h3F800000, 2, 1'b0, 1'b0, 1'b1, 1'b0, 0); // MAX
        do_op(3'd3, 32'h40400000, 32'h40400000, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0); // MIN tie
        do_op(3'd0, 32'h7FC00000, 32'h3F800000, 2, 1'b1, 1'b0, 1'b0, 1'b1, 0); // EQ inv
        do_op(3'd3, 32'h7FC00000, 32'h3F800000, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1); // MIN inv
        do_op(3'd6, 32'h12345678, 32'h9ABCDEF0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0); // illegal
        do_op(3'd2, 32'h40000000, 32'h3F800000, 1000, 1'b0, 1'b1, 1'b0, 1'b0, 0); // timeout
        do_op(3'd1, 32'h3F800000, 32'h40000000, 2, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        do_op(3'd1, 32'h40000000, 32'h3F800000, 4, 1'b0, 1'b1, 1'b0, 1'b0, 0); // stale done masked
        do_op(3'd2, 32'h3F800000, 32'h3F800000, TIMEOUT - 1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        do_op(3'd2, 32'h3F800000, 32'h3F800000, TIMEOUT, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        do_op(3'd2, 32'hBF800000, 32'h3F800000, 3, 1'b0, 1'b0, 1'b1, 1'b0, 5); // stalled response
        reset_mid(0);
        reset_mid(3);
        do_op(3'd4, 32'h3F800000, 32'hC0000000, 2, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        for (int t = 0; t < 150; t++) begin
            logic [2:0] op;
            int r, hold;
            op   = 3'($urandom_range(0, 7));
            r    = $urandom_range(0, 2);
            hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            do_op(op, $urandom, $urandom, $urandom_range(1, TIMEOUT + 2),
                  (r == 0), (r == 1), (r == 2), ($urandom_range(0, 4) == 0), hold);
        end

`ifdef FP_CMP_ISSUE_STATS_EN
        check_value("stat_ops", 32'(stat_ops), 32'(ops_exp));
        check_value("stat_inv", 32'(stat_inv), 32'(inv_exp));
`else
        check_value("stat_ops", 32'(stat_ops), 32'd0);
        check_value("stat_inv", 32'(stat_inv), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_comp_issue.md
Name: fp_comp_issue

Overview:
- Initiator/sequencer for the FP comparator: accepts compare commands on a valid/ready request port.
- Drives operands and act to an external comparator, waits for its registered done/eq/great/less/inv.
- Returns a boolean or selected-operand result on a valid/ready response port.
- Sits between the FPU command decoder and the comparator; single outstanding operation.

Parameters:
- W, 32, operand width (IEEE-754 single).
- LAT, 2, cycles after act before comparator outputs are sampled (comparator output register depth, ≥1).
- TIMEOUT, 16, cycles after act with no done before aborting (> LAT).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when valid&ready
- req_op  in  3  000 EQ, 001 LT, 010 LE, 011 MIN, 100 MAX; 101-111 illegal
- req_a  in  W  operand A
- req_b  in  W  operand B
- cmp_in1  out  W  operand A to comparator
- cmp_in2  out  W  operand B to comparator
- cmp_act  out  1  one-cycle start pulse to comparator
- cmp_eq, cmp_great, cmp_less, cmp_done, cmp_inv  in  1 each  comparator results
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_data  out  W  MIN/MAX selected operand; zero for EQ/LT/LE
- rsp_flag  out  1  boolean result for EQ/LT/LE; 0 for MIN/MAX
- rsp_inv  out  1  invalid (comparator inv or illegal op)
- rsp_timeout  out  1  comparator did not assert done within TIMEOUT
- stat_ops  out  16  operations issued (optional feature)
- stat_inv  out  16  responses with rsp_inv=1 (optional feature)

Behaviour:
- Reset (rst=0, async): state IDLE; req_ready=0; cmp_act=0; cmp_in1/cmp_in2=0; rsp_* all 0; counters 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid:
  - Latch op, a, b.
  - Legal op -> ISSUE.
  - Illegal op -> RESP with rsp_inv=1, flag=0, data=0; no act issued.
- ISSUE (1 cycle): cmp_act=1; cmp_in1/cmp_in2 = latched a/b, held stable until the next accept; cycle counter cleared -> WAIT.
- WAIT: counter increments each cycle.
  - Comparator done/eq/great/less/inv are ignored until counter ≥ LAT, which masks stale done from the prior operation.
  - Counter ≥ LAT and cmp_done=1 -> compute result -> RESP.
  - Counter reaches TIMEOUT without done -> RESP with rsp_timeout=1, rsp_inv=1, flag=0, data=0.
- Result rules, no timeout:
  - cmp_inv=1: flag=0, rsp_inv=1; MIN/MAX data = 32'h7FC00000.
  - EQ: flag=eq.
  - LT: flag=less.
  - LE: flag=less|eq.
  - MIN: data = great ? b : a (ties return a).
  - MAX: data = less ? b : a (ties return a).
- RESP: rsp_valid=1, outputs held stable. On rsp_ready -> IDLE, rsp_valid=0 on the next cycle.
- Throughput: req_ready=0 in every state but IDLE; minimum 1 + 1 + LAT + 1 cycles per op at rsp_ready=1.
- rsp_ready high before rsp_valid has no effect.
- Reset mid-operation: immediate return to IDLE; cmp_act deasserts asynchronously; no response produced.
- Counter width: ceil(log2(TIMEOUT+1)); never wraps — state leaves WAIT at TIMEOUT.

Optional Feature:
- Macro FP_CMP_ISSUE_STATS_EN.
- Defined:
  - stat_ops increments on every ISSUE cycle.
  - stat_inv increments on every RESP handshake with rsp_inv=1.
  - Both saturate at 16'hFFFF; both reset to 0.
- Undefined: stat_ops/stat_inv ports present and tied to 0; no counter logic.

Test Plan:
- LT, a=3F800000 (1.0), b=40000000 (2.0); comparator model less=1 after 2 cycles -> cmp_act single pulse; rsp_flag=1, rsp_inv=0, rsp_data=0, rsp_valid at cycle 4 after accept.
- MAX, a=C0000000, b=3F800000; model less=1 -> rsp_data=3F800000, rsp_flag=0. MIN, a=b=40400000, eq=1 -> rsp_data=40400000.
- EQ with model inv=1, eq=1 -> rsp_flag=0, rsp_inv=1; MIN with inv=1 -> rsp_data=7FC00000.
- req_op=110 -> no cmp_act, rsp_inv=1 on next cycle; stat_inv increments when FP_CMP_ISSUE_STATS_EN is defined.
- Model holds done=0 -> rsp_timeout=1, rsp_inv=1 exactly TIMEOUT cycles after act. Separately, stale done=1 before LAT -> ignored.
- rsp_ready low 5 cycles -> rsp held stable, req_ready=0. Assert rst in WAIT -> all outputs 0 immediately; next request proceeds normally.
